cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Sequencing controller sitting directly upstream of the 32-entry shift-in lookup cache. It accepts one CPU load/store at a time and resolves loads through the lookup. On a load miss it fetches the word from main memory over a request/acknowledge handshake, then shifts `{address, data}` into the lookup. Stores are write-through: memory is always written and the lookup is always refreshed.

## Interface
- `TIMEOUT`, 255: maximum cycles spent in MEM waiting for `MEM_ACK` before abort.
- `CLK` in 1: sole clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `REQ` in 1: CPU request strobe, sampled only in IDLE.
- `WREN` in 1: 1 = store, 0 = load; sampled with `REQ`.
- `ADDR` in 32: CPU word address; sampled with `REQ`.
- `WDATA` in 32: store data; sampled with `REQ`.
- `RDATA` out 32: load result; registered.
- `DONE` out 1: one-cycle completion pulse.
- `ERR` out 1: one-cycle pulse on memory timeout; coincides with `DONE`.
- `BUSY` out 1: high in every state except IDLE.
- `LK_ADDR` out 32: address to lookup; equals latched address register.
- `LK_DIN` out 32: fill data to lookup.
- `LK_WE` out 1: lookup shift-in strobe.
- `LK_DOUT` in 32: lookup data; combinational from `LK_ADDR`.
- `LK_FOUND` in 1: lookup hit flag.
- `MEM_ADDR` out 32: memory address; equals latched address.
- `MEM_WDATA` out 32: memory store data.
- `MEM_RE` out 1: memory read request, level.
- `MEM_WE` out 1: memory write request, level.
- `MEM_RDATA` in 32: memory read data; valid when `MEM_ACK`=1.
- `MEM_ACK` in 1: memory completion, one cycle.
- `HIT_CNT` out 32: load-hit counter, saturating.
- `MISS_CNT` out 32: load-miss counter, saturating.

## Operation
- States: IDLE, LOOKUP, MEM, FILL.
- IDLE
  - If `REQ`=1 at an edge: latch `ADDR`, `WDATA` and `WREN`, then go to LOOKUP.
  - `REQ` is ignored in all other states; there is no queuing.
- LOOKUP (always exactly 1 cycle)
  - Load with `LK_FOUND`=1: `RDATA`<=`LK_DOUT`, `HIT_CNT`++, go to IDLE, `DONE`=1.
  - Load with `LK_FOUND`=0: `MISS_CNT`++, go to MEM.
  - Store: go to MEM regardless of `LK_FOUND`; counters are not touched.
- MEM
  - Load: `MEM_RE`=1.
  - Store: `MEM_WE`=1 with `MEM_WDATA` = latched data.
  - Request is held level until `MEM_ACK` is sampled high.
  - On ACK for a load: capture `MEM_RDATA` into `RDATA` and the fill register.
  - On ACK for a store: fill register <= latched data.
  - After ACK, go to FILL.
  - A wait counter increments each MEM cycle. On reaching `TIMEOUT` without ACK: drop the request, go to IDLE, pulse `DONE`+`ERR`. No fill, no `RDATA` change.
- FILL (always exactly 1 cycle)
  - `LK_WE`=1, `LK_DIN` = fill register.
  - Then go to IDLE, `DONE`=1.
- A store therefore shadows any older lookup entry for the same address, because the newest entry wins.
- Counters saturate at 0xFFFFFFFF.
- `MEM_ACK` in IDLE, LOOKUP or FILL is ignored.

## Timing
- Reset values: state IDLE; `RDATA`, `DONE`, `ERR`, `BUSY`, `LK_WE`, `MEM_RE`, `MEM_WE` = 0; address, fill and data registers = 0; both counters = 0.
- `RST` mid-transaction:
  - Next cycle: IDLE, requests deasserted.
  - No `DONE` and no fill.
  - A late `MEM_ACK` is ignored.
- Edge 0 is the edge sampling `REQ`.
- Load hit: LOOKUP in cycle 1, `DONE` high in cycle 2, i.e. 2-cycle latency.
- Load miss with ACK on the first MEM cycle:
  - LOOKUP cycle 1, MEM cycle 2, FILL cycle 3, `DONE` cycle 4.
  - Each extra wait cycle adds 1.
- Store follows the same timing as a miss.
- `DONE` is asserted in an IDLE cycle, and `REQ` may be sampled in that same cycle, so back-to-back requests are allowed. `RDATA` holds until the next load completes.
- `BUSY` drops in the cycle `DONE` rises.

## Test plan
- Reset, then load 0x100 with the lookup empty and memory returning 0xDEADBEEF after 3 wait cycles -> `MEM_RE` high for 4 cycles; `LK_WE` one pulse with `LK_DIN`=0xDEADBEEF; `DONE` at cycle 7; `RDATA`=0xDEADBEEF; `MISS_CNT`=1.
- Repeat load 0x100 -> no `MEM_RE`; `DONE` at cycle 2; `RDATA`=0xDEADBEEF; `HIT_CNT`=1.
- Store 0x100 = 0x12345678, then load 0x100 -> `MEM_WE` with `MEM_WDATA`=0x12345678; the load hits and returns 0x12345678; counters only see the load.
- Load 0x200 and never assert ACK (`TIMEOUT`=8) -> after 8 MEM cycles: `DONE`+`ERR` pulse, `RDATA` unchanged, `LK_WE` never asserted.
- Assert `RST` during MEM of a load, then `MEM_ACK` the following cycle -> IDLE, no `DONE`, no `LK_WE`, counters 0.
- Hold `REQ` high through two consecutive hits -> second request sampled in the first `DONE` cycle; `DONE` pulses 2 cycles apart.

Source files
------------

// File: rtl/cache_ctrl.sv
// Sequencing controller in front of a 32-entry shift-in lookup cache.
// Loads resolve through the lookup or main memory; stores write through and refresh the lookup.
module cache_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic        WREN,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic [31:0] RDATA,
  output logic        DONE,
  output logic        ERR,
  output logic        BUSY,
  output logic [31:0] LK_ADDR,
  output logic [31:0] LK_DIN,
  output logic        LK_WE,
  input  logic [31:0] LK_DOUT,
  input  logic        LK_FOUND,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic        MEM_RE,
  output logic        MEM_WE,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ACK,
  output logic [31:0] HIT_CNT,
  output logic [31:0] MISS_CNT
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_MEM    = 2'd2;
  localparam logic [1:0] S_FILL   = 2'd3;

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   fill_q, fill_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   hit_q, hit_d;
  logic [31:0]   miss_q, miss_d;
  logic          wren_q, wren_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [CW-1:0] wait_q, wait_d;

  // Next-state logic; DONE/ERR are registered so they appear in the following IDLE cycle.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    fill_d  = fill_q;
    rdata_d = rdata_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    wren_d  = wren_q;
    wait_d  = wait_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (REQ) begin
          addr_d  = ADDR;
          data_d  = WDATA;
          wren_d  = WREN;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        wait_d = '0;
        if (!wren_q && LK_FOUND) begin
          rdata_d = LK_DOUT;
          if (hit_q != 32'hFFFF_FFFF) hit_d = hit_q + 32'd1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          if (!wren_q && miss_q != 32'hFFFF_FFFF) miss_d = miss_q + 32'd1;
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        if (MEM_ACK) begin
          if (!wren_q) begin
            rdata_d = MEM_RDATA;
            fill_d  = MEM_RDATA;
          end else begin
            fill_d  = data_q;
          end
          state_d = S_FILL;
        end else if (wait_q == CW'(TIMEOUT - 1)) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_FILL: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      fill_q  <= '0;
      rdata_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      wren_q  <= 1'b0;
      wait_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      wren_q  <= wren_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Memory requests are levels derived from state, so a timeout or reset drops them at once.
  assign RDATA     = rdata_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign BUSY      = (state_q != S_IDLE);
  assign LK_ADDR   = addr_q;
  assign LK_DIN    = fill_q;
  assign LK_WE     = (state_q == S_FILL);
  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = data_q;
  assign MEM_RE    = (state_q == S_MEM) && !wren_q;
  assign MEM_WE    = (state_q == S_MEM) && wren_q;
  assign HIT_CNT   = hit_q;
  assign MISS_CNT  = miss_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: models the shift-in lookup and main memory around the DUT and
// predicts each transaction's latency and results from the controller's behavioural rules.
module tb_cache_ctrl;

  localparam int TIMEOUT = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ = 1'b0;
  logic        WREN = 1'b0;
  logic [31:0] ADDR = '0;
  logic [31:0] WDATA = '0;
  logic [31:0] RDATA;
  logic        DONE, ERR, BUSY;
  logic [31:0] LK_ADDR, LK_DIN;
  logic        LK_WE;
  logic [31:0] lkDout;
  logic        lkFound;
  logic [31:0] MEM_ADDR, MEM_WDATA;
  logic        MEM_RE, MEM_WE;
  logic [31:0] MEM_RDATA = '0;
  logic        MEM_ACK = 1'b0;
  logic [31:0] HIT_CNT, MISS_CNT;

  int nChecks = 0;
  int nFail = 0;

  cache_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WREN(WREN), .ADDR(ADDR), .WDATA(WDATA),
    .RDATA(RDATA), .DONE(DONE), .ERR(ERR), .BUSY(BUSY),
    .LK_ADDR(LK_ADDR), .LK_DIN(LK_DIN), .LK_WE(LK_WE), .LK_DOUT(lkDout), .LK_FOUND(lkFound),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE),
    .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK), .HIT_CNT(HIT_CNT), .MISS_CNT(MISS_CNT)
  );

  always #5 CLK = ~CLK;

  // External 32-entry shift-in lookup; index 0 is the newest entry and wins on duplicates.
  logic [31:0] lkA [32];
  logic [31:0] lkD [32];
  bit          lkV [32];

  always_comb begin
    lkFound = 1'b0;
    lkDout  = '0;
    for (int i = 31; i >= 0; i--) begin
      if (lkV[i] && lkA[i] == LK_ADDR) begin
        lkFound = 1'b1;
        lkDout  = lkD[i];
      end
    end
  end

  always @(posedge CLK) begin
    if (LK_WE) begin
      for (int i = 31; i > 0; i--) begin
        lkA[i] <= lkA[i-1];
        lkD[i] <= lkD[i-1];
        lkV[i] <= lkV[i-1];
      end
      lkA[0] <= LK_ADDR;
      lkD[0] <= LK_DIN;
      lkV[0] <= 1'b1;
    end
  end

  // Reference state: recently filled addresses (newest first), memory contents, expected outputs.
  logic [31:0] refQ[$];
  logic [31:0] refData [logic [31:0]];
  logic [31:0] memData [logic [31:0]];
  logic [31:0] expRdata = '0;
  logic [31:0] expHits = '0;
  logic [31:0] expMisses = '0;

  function automatic bit inRef(input logic [31:0] a);
    foreach (refQ[i]) if (refQ[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void refFill(input logic [31:0] a, input logic [31:0] d);
    refQ.push_front(a);
    if (refQ.size() > 32) void'(refQ.pop_back());
    refData[a] = d;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one CPU transaction; the memory acknowledges on MEM cycle waits+1 unless noAck.
  task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                               input int waits, input bit noAck);
    bit          expHit;
    logic [31:0] rdVal;
    int          expDone, memCyc, reCyc, weCyc, strobes, doneCyc;
    logic        errSeen, busy1, wdOk, addrOk;
    logic [31:0] dinSeen, lkAddr1;
    memCyc = 0; reCyc = 0; weCyc = 0; strobes = 0; doneCyc = -1;
    errSeen = 1'b0; busy1 = 1'b0; wdOk = 1'b1; addrOk = 1'b1;
    dinSeen = '0; lkAddr1 = '0;
    expHit = !wr && inRef(a);
    rdVal  = memData.exists(a) ? memData[a] : $urandom;
    REQ = 1'b1; WREN = wr; ADDR = a; WDATA = wd;
    @(posedge CLK); #1;
    REQ = 1'b0; ADDR = $urandom; WDATA = $urandom; WREN = $urandom_range(0, 1);
    for (int c = 1; c <= TIMEOUT + 10; c++) begin
      MEM_ACK = 1'b0;
      MEM_RDATA = $urandom;
      if (c == 1) begin
        busy1 = BUSY;
        lkAddr1 = LK_ADDR;
      end
      if (MEM_RE || MEM_WE) begin
        memCyc++;
        if (MEM_RE) reCyc++;
        if (MEM_WE) begin
          weCyc++;
          if (MEM_WDATA !== wd) wdOk = 1'b0;
        end
        if (MEM_ADDR !== a) addrOk = 1'b0;
        if (!noAck && memCyc == waits + 1) begin
          MEM_ACK = 1'b1;
          if (!wr) MEM_RDATA = rdVal;
        end
      end
      if (LK_WE) begin
        strobes++;
        dinSeen = LK_DIN;
      end
      if (DONE) begin
        doneCyc = c;
        errSeen = ERR;
        break;
      end
      @(posedge CLK); #1;
    end
    MEM_ACK = 1'b0;

    if (expHit) begin
      expDone = 2;
      expRdata = refData[a];
      expHits++;
      checkOutput("memCycles", 32'(memCyc), 32'd0);
      checkOutput("fillStrobes", 32'(strobes), 32'd0);
    end else if (noAck) begin
      expDone = TIMEOUT + 2;
      if (!wr) expMisses++;
      checkOutput("memCycles", 32'(memCyc), 32'(TIMEOUT));
      checkOutput("fillStrobes", 32'(strobes), 32'd0);
    end else begin
      expDone = 4 + waits;
      if (!wr) begin
        expMisses++;
        expRdata = rdVal;
        memData[a] = rdVal;
        refFill(a, rdVal);
        checkOutput("readCycles", 32'(reCyc), 32'(waits + 1));
        checkOutput("fillData", dinSeen, rdVal);
      end else begin
        memData[a] = wd;
        refFill(a, wd);
        checkOutput("writeCycles", 32'(weCyc), 32'(waits + 1));
        checkOutput("writeData", 32'(wdOk), 32'd1);
        checkOutput("fillData", dinSeen, wd);
      end
      checkOutput("fillStrobes", 32'(strobes), 32'd1);
    end
    if (wr) checkOutput("noReadOnStore", 32'(reCyc), 32'd0);
    else    checkOutput("noWriteOnLoad", 32'(weCyc), 32'd0);
    checkOutput("memAddr", 32'(addrOk), 32'd1);
    checkOutput("busyLookup", 32'(busy1), 32'd1);
    checkOutput("lkAddr", lkAddr1, a);
    checkOutput("doneCycle", 32'(doneCyc), 32'(expDone));
    checkOutput("err", 32'(errSeen), 32'(noAck && !expHit));
    checkOutput("busyAtDone", 32'(BUSY), 32'd0);
    checkOutput("rdata", RDATA, expRdata);
    checkOutput("hitCnt", HIT_CNT, expHits);
    checkOutput("missCnt", MISS_CNT, expMisses);
  endtask

  initial begin
    logic [31:0] pool [7];
    logic [31:0] ra;
    bit          rw, rna;
    int          rwait;
    for (int i = 0; i < 6; i++) pool[i] = 32'h400 + 32'(4 * i);
    pool[6] = 32'h100;

    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    checkOutput("rstRdata", RDATA, 32'd0);
    checkOutput("rstDone", 32'(DONE), 32'd0);
    checkOutput("rstErr", 32'(ERR), 32'd0);
    checkOutput("rstBusy", 32'(BUSY), 32'd0);
    checkOutput("rstLkWe", 32'(LK_WE), 32'd0);
    checkOutput("rstMemRe", 32'(MEM_RE), 32'd0);
    checkOutput("rstMemWe", 32'(MEM_WE), 32'd0);
    checkOutput("rstLkAddr", LK_ADDR, 32'd0);
    checkOutput("rstLkDin", LK_DIN, 32'd0);
    checkOutput("rstMemWdata", MEM_WDATA, 32'd0);
    checkOutput("rstHits", HIT_CNT, 32'd0);
    checkOutput("rstMisses", MISS_CNT, 32'd0);

    $display("[TB] directed: miss with 3 wait cycles, hit, store then load, timeout");
    memData[32'h100] = 32'hDEAD_BEEF;
    applyStimulus(1'b0, 32'h100, 32'h0, 3, 1'b0);
    checkOutput("missRdata", RDATA, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h100, 32'h0, 0, 1'b0);
    checkOutput("hitRdata", RDATA, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 32'h100, 32'h1234_5678, 0, 1'b0);
    applyStimulus(1'b0, 32'h100, 32'h0, 0, 1'b0);
    checkOutput("storeShadow", RDATA, 32'h1234_5678);
    applyStimulus(1'b0, 32'h200, 32'h0, 0, 1'b1);

    $display("[TB] directed: REQ held through two hits");
    REQ = 1'b1; WREN = 1'b0; ADDR = 32'h100;
    for (int c = 1; c <= 4; c++) begin
      @(posedge CLK); #1;
      if (c == 3) REQ = 1'b0;
      checkOutput($sformatf("heldDone%0d", c), 32'(DONE), 32'(c == 2 || c == 4));
    end
    expHits += 2;
    expRdata = refData[32'h100];
    checkOutput("heldHits", HIT_CNT, expHits);
    checkOutput("heldRdata", RDATA, expRdata);

    $display("[TB] directed: reset during MEM with a late acknowledge");
    REQ = 1'b1; WREN = 1'b0; ADDR = 32'h300;
    @(posedge CLK); #1;
    REQ = 1'b0;
    @(posedge CLK); #1;
    checkOutput("rstMidMemRe", 32'(MEM_RE), 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    MEM_ACK = 1'b1;
    MEM_RDATA = 32'hCAFE_F00D;
    checkOutput("rstMidBusy", 32'(BUSY), 32'd0);
    checkOutput("rstMidMemRe2", 32'(MEM_RE), 32'd0);
    checkOutput("rstMidDone", 32'(DONE), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      MEM_ACK = 1'b0;
      checkOutput("rstLateDone", 32'(DONE), 32'd0);
      checkOutput("rstLateLkWe", 32'(LK_WE), 32'd0);
      checkOutput("rstLateBusy", 32'(BUSY), 32'd0);
    end
    expHits = '0;
    expMisses = '0;
    expRdata = '0;
    checkOutput("rstMidHits", HIT_CNT, 32'd0);
    checkOutput("rstMidMisses", MISS_CNT, 32'd0);
    checkOutput("rstMidRdata", RDATA, 32'd0);

    $display("[TB] random transactions");
    for (int n = 0; n < 60; n++) begin
      ra = pool[$urandom_range(0, 6)];
      rw = ($urandom_range(0, 2) == 0);
      rna = ($urandom_range(0, 7) == 0);
      rwait = $urandom_range(0, 3);
      applyStimulus(rw, ra, $urandom, rwait, rna);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
